mole_sequencer: RTL
===================

MOLE_SEQUENCER -- requirements
Module: mole_sequencer

Interface
REQ-001 Parameter UP_CYCLES, default 50000000: clock cycles a mole stays up; legal range 2..2^26-1.
REQ-002 Parameter GAP_CYCLES, default 25000000: clock cycles with no mole between pops; legal range 1..2^26-1.
REQ-003 Port clk, input, 1: system clock; all logic on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port start, input, 1: begin-game request, sampled every cycle.
REQ-006 Port btn, input, 4: hole buttons, already synchronised, active-high level.
REQ-007 Port mole, output, 4: one-hot mole LED drive, or all zero.
REQ-008 Port hit, output, 1: one-cycle pulse on a correct whack.
REQ-009 Port miss, output, 1: one-cycle pulse on a wrong press or timeout.
REQ-010 Port score, output, 8: hit count for the current game.
REQ-011 Port busy, output, 1: high in every state except IDLE.
REQ-012 Port game_over, output, 1: high in DONE.

Function
REQ-013 States: IDLE, GAP, UP and DONE; DONE exists only per REQ-029; all outputs registered.
REQ-014 Internal registered edge detect: press = btn & ~btn_q; only press is used, so a held button counts once.
REQ-015 8-bit LFSR, seed 8'hA5: polynomial x^8+x^6+x^5+x^4+1; advances every cycle in every state; never reaches zero.
REQ-016 IDLE: mole=0; start -> GAP, clear score and timer.
REQ-017 start is ignored in GAP and UP.
REQ-018 GAP: mole=0; timer counts 0..GAP_CYCLES-1; on the last count -> UP, mole = 4'b0001 << lfsr[1:0] as sampled that cycle; timer cleared.
REQ-019 Presses in GAP, IDLE and DONE are ignored and produce no pulse.
REQ-020 UP, press equal to mole with no other bit set -> hit=1 for one cycle, score+1 saturating at 255, -> GAP, mole=0 next cycle.
REQ-021 UP, any press bit outside mole -> miss=1 for one cycle, -> GAP; this applies even if the mole bit is pressed in the same cycle.
REQ-022 UP, no press and timer reaches UP_CYCLES-1 -> miss=1, -> GAP.
REQ-023 A correct press on the final UP cycle counts as a hit; press takes priority over timeout.
REQ-024 hit and miss are never high in the same cycle.
REQ-025 score holds its value in IDLE and DONE until the next start.

Reset
REQ-026 rst=1 at a clock edge: state=IDLE, mole=0, hit=0, miss=0, score=0, game_over=0, timer=0, LFSR=8'hA5, btn_q=0.
REQ-027 rst takes priority over every other input in the same cycle, including mid-UP and a simultaneous start.
REQ-028 First press is detectable on the second cycle after reset release.

Configuration
REQ-029 With MOLE_SEQ_STRIKE_LIMIT_EN defined:
- a 2-bit miss counter is cleared on start and incremented on each miss;
- the third miss moves the block to DONE instead of GAP (mole=0, busy=1, game_over=1);
- start in DONE -> GAP, clears score and the miss counter, and sets game_over=0.
REQ-030 Without MOLE_SEQ_STRIKE_LIMIT_EN: there is no miss counter and no DONE state; game_over is tied to 0; the game runs until rst.

Verification
Bench parameters: UP_CYCLES=4, GAP_CYCLES=2.
REQ-031 Reset, then one start pulse -> busy=1 next cycle; mole=0 for 2 cycles; then mole one-hot matching the reference LFSR model; score=0.
REQ-032 Press the lit hole 1 cycle into UP -> hit=1 for exactly 1 cycle; score=1; mole=0 next cycle; holding the button through the next UP gives no second hit.
REQ-033 No press in UP -> miss=1 exactly 4 cycles after mole rises; score unchanged.
REQ-034 Press lit and unlit holes in the same cycle -> miss=1, hit=0; then a correct press on the 4th UP cycle -> hit=1.
REQ-035 Force score=255 via 255 hits, then one more hit -> score stays 255; rst asserted mid-UP -> next cycle mole=0, score=0, busy=0.
REQ-036 With MOLE_SEQ_STRIKE_LIMIT_EN: three timeouts -> game_over=1, mole=0, presses ignored; start -> game_over=0, score=0, GAP entered.

Source files
------------

// File: rtl/mole_sequencer.sv
// rtl/mole_sequencer.sv - whack-a-mole game sequencer (optional strike limit via MOLE_SEQ_STRIKE_LIMIT_EN)
module mole_sequencer #(
  parameter int unsigned UP_CYCLES  = 50000000,
  parameter int unsigned GAP_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] btn,
  output logic [3:0] mole,
  output logic       hit,
  output logic       miss,
  output logic [7:0] score,
  output logic       busy,
  output logic       game_over
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GAP  = 2'd1,
    S_UP   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [25:0] GAP_LAST = 26'(GAP_CYCLES - 1);
  localparam logic [25:0] UP_LAST  = 26'(UP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [25:0] timer_q, timer_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [3:0]  btn_q, btn_d;
  logic [3:0]  mole_q, mole_d;
  logic        hit_q, hit_d;
  logic        miss_q, miss_d;
  logic [7:0]  score_q, score_d;
  logic        busy_q, busy_d;
  logic [3:0]  press;
  logic        miss_event;
`ifdef MOLE_SEQ_STRIKE_LIMIT_EN
  logic [1:0]  strikes_q, strikes_d;
  logic        game_over_q, game_over_d;
`endif

  // Next-state logic: press edge detect, LFSR step, game state machine
  always_comb begin
    press      = btn & ~btn_q;
    btn_d      = btn;
    // x^8+x^6+x^5+x^4+1, shifted left; a non-zero seed never decays to zero
    lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    state_d    = state_q;
    timer_d    = timer_q;
    mole_d     = mole_q;
    hit_d      = 1'b0;
    miss_d     = 1'b0;
    score_d    = score_q;
    miss_event = 1'b0;
`ifdef MOLE_SEQ_STRIKE_LIMIT_EN
    strikes_d  = strikes_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_GAP;
          timer_d   = 26'd0;
          score_d   = 8'd0;
`ifdef MOLE_SEQ_STRIKE_LIMIT_EN
          strikes_d = 2'd0;
`endif
        end
      end
      S_GAP: begin
        if (timer_q == GAP_LAST) begin
          state_d = S_UP;
          timer_d = 26'd0;
          mole_d  = 4'b0001 << lfsr_q[1:0];
        end else begin
          timer_d = timer_q + 26'd1;
        end
      end
      S_UP: begin
        if (press != 4'd0) begin
          // mole is one-hot, so "nothing outside mole" means exactly the lit hole
          if ((press & ~mole_q) == 4'd0) begin
            hit_d   = 1'b1;
            score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
            state_d = S_GAP;
            timer_d = 26'd0;
            mole_d  = 4'd0;
          end else begin
            miss_event = 1'b1;
          end
        end else if (timer_q == UP_LAST) begin
          miss_event = 1'b1;
        end else begin
          timer_d = timer_q + 26'd1;
        end
      end
`ifdef MOLE_SEQ_STRIKE_LIMIT_EN
      S_DONE: begin
        if (start) begin
          state_d   = S_GAP;
          timer_d   = 26'd0;
          score_d   = 8'd0;
          strikes_d = 2'd0;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        timer_d = 26'd0;
        mole_d  = 4'd0;
      end
    endcase

    if (miss_event) begin
      miss_d  = 1'b1;
      mole_d  = 4'd0;
      timer_d = 26'd0;
      state_d = S_GAP;
`ifdef MOLE_SEQ_STRIKE_LIMIT_EN
      if (strikes_q == 2'd2) begin
        state_d = S_DONE;
      end
      strikes_d = strikes_q + 2'd1;
`endif
    end

    busy_d = (state_d != S_IDLE);
`ifdef MOLE_SEQ_STRIKE_LIMIT_EN
    game_over_d = (state_d == S_DONE);
`endif
  end

  // State and registered outputs, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= 26'd0;
      lfsr_q  <= 8'hA5;
      btn_q   <= 4'd0;
      mole_q  <= 4'd0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      score_q <= 8'd0;
      busy_q  <= 1'b0;
`ifdef MOLE_SEQ_STRIKE_LIMIT_EN
      strikes_q   <= 2'd0;
      game_over_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      lfsr_q  <= lfsr_d;
      btn_q   <= btn_d;
      mole_q  <= mole_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      score_q <= score_d;
      busy_q  <= busy_d;
`ifdef MOLE_SEQ_STRIKE_LIMIT_EN
      strikes_q   <= strikes_d;
      game_over_q <= game_over_d;
`endif
    end
  end

  assign mole  = mole_q;
  assign hit   = hit_q;
  assign miss  = miss_q;
  assign score = score_q;
  assign busy  = busy_q;
`ifdef MOLE_SEQ_STRIKE_LIMIT_EN
  assign game_over = game_over_q;
`else
  assign game_over = 1'b0;
`endif

endmodule
